charge_timer: RTL and testbench

Parametrised successor to the single-shot charge timer: a programmable countdown in whole seconds, driven from the 1000 Hz reduced clock.
- The coin/payment logic adds credit seconds at any time.
- The controller starts, pauses and cancels the session.
- The block reports remaining seconds to the display, holds `timing` high while the charger relay is on, and pulses `done` on natural expiry.

---
 rtl/charger_pkg.sv | 12 +
 rtl/sec_tick_gen.sv | 25 ++
 rtl/charge_timer.sv | 86 ++++++++
 tb/tb_charge_timer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/charger_pkg.sv
// Shared charger definitions: FSM state encoding and system-wide defaults
// used by the timer, display and coin modules.
package charger_pkg;
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;

  localparam int DEF_TICKS_PER_SEC = 1000;
  localparam int DEF_MAX_SEC       = 9999;
endpackage

// File: rtl/sec_tick_gen.sv
// Seconds prescaler: counts enabled cycles and pulses sec_tick on the last
// cycle of each second. Holds its count while disabled so partial seconds survive.
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic sec_tick
);
  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;

  assign sec_tick = enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear)
      cnt <= '0;
    else if (enable)
      cnt <= sec_tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/charge_timer.sv
// Programmable whole-second charge countdown with credit top-up, pause and cancel.
// All outputs are registered; credit saturates at MAX_SEC.
module charge_timer
  import charger_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int SEC_W         = 14,
  parameter int MAX_SEC       = DEF_MAX_SEC,
  parameter int ADD_W         = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             add_en,
  input  logic [ADD_W-1:0] add_sec,
  input  logic             start,
  input  logic             pause,
  input  logic             cancel,
  output logic [SEC_W-1:0] remaining,
  output logic             timing,
  output logic             done,
  output state_t           state
);
  localparam logic [SEC_W:0] MAX_W = (SEC_W+1)'(MAX_SEC);

  logic             sec_tick;
  logic             tick_en;
  logic             go_run;
  logic             expire;
  logic [SEC_W:0]   sum;
  logic [SEC_W-1:0] nxt_rem;
  state_t           nxt_st;

  // Pause wins over the tick in the cycle it is seen, so the prescaler freezes there.
  assign tick_en = (state == ST_RUN) && !pause && !cancel;
  assign go_run  = (state == ST_IDLE) && (nxt_st == ST_RUN);

  sec_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .clear    (cancel || go_run),
    .enable   (tick_en),
    .sec_tick (sec_tick)
  );

  // One extra bit of headroom so credit plus remaining can be clamped, not wrapped.
  always_comb begin
    sum = {1'b0, remaining};
    if (add_en)
      sum = sum + (SEC_W+1)'(add_sec);
    if (sec_tick && (sum != '0))
      sum = sum - 1'b1;
    nxt_rem = (sum > MAX_W) ? MAX_W[SEC_W-1:0] : sum[SEC_W-1:0];
  end

  always_comb begin
    nxt_st = state;
    expire = 1'b0;
    case (state)
      ST_IDLE:  if (start && (nxt_rem != '0)) nxt_st = ST_RUN;
      ST_RUN: begin
        if (pause)
          nxt_st = ST_PAUSE;
        else if (sec_tick && (nxt_rem == '0)) begin
          nxt_st = ST_IDLE;
          expire = 1'b1;
        end
      end
      ST_PAUSE: if (!pause && start) nxt_st = ST_RUN;
      default:  nxt_st = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || cancel) begin
      remaining <= '0;
      state     <= ST_IDLE;
      timing    <= 1'b0;
      done      <= 1'b0;
    end else begin
      remaining <= nxt_rem;
      state     <= nxt_st;
      timing    <= (nxt_st == ST_RUN);
      done      <= expire;
    end
  end
endmodule

// File: tb/tb_charge_timer.sv
module tb_charge_timer;
  import charger_pkg::*;

  localparam int SEC_W = 14;
  localparam int ADD_W = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             add_en = 1'b0;
  logic [ADD_W-1:0] add_sec = '0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             cancel = 1'b0;
  logic [SEC_W-1:0] remaining;
  logic             timing;
  logic             done;
  logic [1:0]       state;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int         at;
    string      nm;
    int         rem;
    logic       tim;
    logic       dn;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];

  charge_timer #(
    .TICKS_PER_SEC(4),
    .SEC_W        (SEC_W),
    .MAX_SEC      (9999),
    .ADD_W        (ADD_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .add_en    (add_en),
    .add_sec   (add_sec),
    .start     (start),
    .pause     (pause),
    .cancel    (cancel),
    .remaining (remaining),
    .timing    (timing),
    .done      (done),
    .state     (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int d, input string nm, input int rem,
                           input logic tim, input logic dn, input logic [1:0] st);
    exp_t e;
    e.at = cyc + d; e.nm = nm; e.rem = rem; e.tim = tim; e.dn = dn; e.st = st;
    q.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      total++;
      if (e.at != cyc || remaining != SEC_W'(e.rem) || timing !== e.tim ||
          done !== e.dn || state !== e.st) begin
        bad++;
        $display("FAIL %s @cyc %0d (due %0d): got rem=%0d timing=%0b done=%0b state=%0d, want rem=%0d timing=%0b done=%0b state=%0d",
                 e.nm, cyc, e.at, remaining, timing, done, state, e.rem, e.tim, e.dn, e.st);
      end
    end
  end

  initial begin
    step(2);
    expect_at(1, "reset_state", 0, 0, 0, ST_IDLE);
    step();
    reset = 1'b0;
    total++;
    if (remaining !== '0 || timing !== 1'b0 || done !== 1'b0 || state !== ST_IDLE) begin
      bad++;
      $display("FAIL direct_reset: rem=%0d timing=%0b done=%0b state=%0d",
               remaining, timing, done, state);
    end

    add_en = 1; add_sec = 3;
    expect_at(1, "add3_idle", 3, 0, 0, ST_IDLE);
    step();
    add_en = 0; start = 1;
    expect_at(1,  "start_timing", 3, 1, 0, ST_RUN);
    expect_at(4,  "no_early_dec", 3, 1, 0, ST_RUN);
    expect_at(5,  "dec_to_2",     2, 1, 0, ST_RUN);
    expect_at(9,  "dec_to_1",     1, 1, 0, ST_RUN);
    expect_at(13, "expire",       0, 0, 1, ST_IDLE);
    expect_at(14, "done_one_cyc", 0, 0, 0, ST_IDLE);
    step();
    start = 0;
    step(13);

    add_en = 1; add_sec = 5;
    step();
    add_en = 0; start = 1;
    expect_at(1,  "p_run",        5, 1, 0, ST_RUN);
    expect_at(4,  "p_paused",     5, 0, 0, ST_PAUSE);
    expect_at(12, "p_frozen",     5, 0, 0, ST_PAUSE);
    expect_at(14, "p_resumed",    5, 1, 0, ST_RUN);
    expect_at(15, "p_partial",    5, 1, 0, ST_RUN);
    expect_at(16, "p_dec_4",      4, 1, 0, ST_RUN);
    expect_at(20, "p_dec_3",      3, 1, 0, ST_RUN);
    expect_at(31, "p_last_sec",   1, 1, 0, ST_RUN);
    expect_at(32, "p_expire",     0, 0, 1, ST_IDLE);
    expect_at(33, "p_done_clear", 0, 0, 0, ST_IDLE);
    step();
    start = 0;
    step(2);
    pause = 1;
    step(10);
    pause = 0; start = 1;
    step();
    start = 0;
    step(19);

    add_en = 1;
    for (int i = 0; i < 9; i++) begin
      add_sec = 10'd1000;
      step();
    end
    add_sec = 10'd990;
    expect_at(1, "sat_9990", 9990, 0, 0, ST_IDLE);
    step();
    add_sec = 10'd500;
    expect_at(1, "sat_ceiling", 9999, 0, 0, ST_IDLE);
    step();
    add_sec = 10'd0;
    expect_at(1, "add_zero", 9999, 0, 0, ST_IDLE);
    step();
    total++;
    if (remaining !== SEC_W'(9999) || state !== ST_IDLE) begin
      bad++;
      $display("FAIL direct_sat: rem=%0d state=%0d", remaining, state);
    end
    add_en = 0; cancel = 1;
    expect_at(1, "cancel_idle", 0, 0, 0, ST_IDLE);
    step();
    cancel = 0;
    total++;
    if (remaining !== '0 || state !== ST_IDLE || done !== 1'b0) begin
      bad++;
      $display("FAIL direct_cancel: rem=%0d done=%0b state=%0d", remaining, done, state);
    end

    add_en = 1; add_sec = 1; start = 1;
    expect_at(1, "start_with_add", 1, 1, 0, ST_RUN);
    step();
    add_en = 0; start = 0;
    step(3);
    add_en = 1; add_sec = 5;
    expect_at(1, "add_on_last_tick", 5, 1, 0, ST_RUN);
    expect_at(2, "no_done_on_add",   5, 1, 0, ST_RUN);
    step();
    add_en = 0;
    step();
    cancel = 1;
    expect_at(1, "cancel_run", 0, 0, 0, ST_IDLE);
    step();
    cancel = 0;

    add_en = 1; add_sec = 7; start = 1;
    expect_at(1, "run7", 7, 1, 0, ST_RUN);
    step();
    add_en = 0; start = 0;
    step();
    cancel = 1; add_en = 1; add_sec = 9;
    expect_at(1, "cancel_drops_add", 0, 0, 0, ST_IDLE);
    expect_at(2, "cancel_no_done",   0, 0, 0, ST_IDLE);
    step();
    cancel = 0; add_en = 0;
    step();

    add_en = 1; add_sec = 7; start = 1;
    expect_at(1, "run7_b", 7, 1, 0, ST_RUN);
    step();
    add_en = 0; start = 0;
    step();
    reset = 1; add_en = 1; add_sec = 9;
    expect_at(1, "reset_mid_run", 0, 0, 0, ST_IDLE);
    step();
    reset = 0; add_en = 0;
    add_en = 1; add_sec = 2; start = 1;
    expect_at(1, "post_reset_run", 2, 1, 0, ST_RUN);
    expect_at(4, "post_reset_hold", 2, 1, 0, ST_RUN);
    expect_at(5, "post_reset_dec", 1, 1, 0, ST_RUN);
    step();
    add_en = 0; start = 0;
    step(4);
    cancel = 1;
    step();
    cancel = 0;

    start = 1;
    for (int i = 0; i < 10; i++) begin
      expect_at(1, "zero_credit_start", 0, 0, 0, ST_IDLE);
      step();
    end
    start = 0;
    step(3);
    total++;
    if (state !== ST_IDLE || timing !== 1'b0 || done !== 1'b0 || remaining !== '0) begin
      bad++;
      $display("FAIL direct_zero_credit: rem=%0d timing=%0b done=%0b state=%0d",
               remaining, timing, done, state);
    end

    while (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s: never checked, due cyc %0d, now %0d", q[0].nm, q[0].at, cyc);
      void'(q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
